// File: rtl/iitk_mini_mips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : iitk_mini_mips_pkg                                 |
// | Description : Shared constants and types for the EX/WB datapath. |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package iitk_mini_mips_pkg;

    localparam int HILO_WE_HI = 1;
    localparam int HILO_WE_LO = 0;
    localparam int HILO_W     = 64;

    typedef logic [1:0] hilo_we_t;

endpackage : iitk_mini_mips_pkg
`default_nettype wire

// File: rtl/ex_wb_stage_hilo_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : hilo_reg                                           |
// | Description : Architectural HI/LO pair with per-half writes.     |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module hilo_reg
    import iitk_mini_mips_pkg::*;
#(
    parameter int PAIR_W = HILO_W
) (
    input  logic              clk,
    input  logic              rst,
    input  hilo_we_t          i_we,
    input  logic [PAIR_W-1:0] i_hilo,
    output logic [PAIR_W-1:0] o_hilo
);

    localparam int c_half_w = PAIR_W / 2;

    logic [c_half_w-1:0] r_hi;
    logic [c_half_w-1:0] r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (i_we[HILO_WE_HI]) r_hi <= i_hilo[PAIR_W-1 -: c_half_w];
            if (i_we[HILO_WE_LO]) r_lo <= i_hilo[c_half_w-1:0];
        end
    end

    assign o_hilo = {r_hi, r_lo};

endmodule : hilo_reg
`default_nettype wire

// File: rtl/ex_wb_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : ex_wb_stage                                        |
// | Description : Two-entry skid buffer toward writeback, HI/LO      |
// |               commit and newest-HI/LO forwarding to the ALU.     |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module ex_wb_stage
    import iitk_mini_mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_result,
    input  logic [2*DATA_W-1:0] in_mul,
    input  logic [RADDR_W-1:0]  in_rd,
    input  logic                in_reg_we,
    input  hilo_we_t            in_hilo_we,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_result,
    output logic [RADDR_W-1:0]  out_rd,
    output logic                out_reg_we,
    output logic [2*DATA_W-1:0] hilo_fwd,
    output logic [2*DATA_W-1:0] hilo_arch
);

    localparam int c_hilo_w = 2 * DATA_W;

    logic                r_main_valid;
    logic [DATA_W-1:0]   r_main_result;
    logic [RADDR_W-1:0]  r_main_rd;
    logic                r_main_reg_we;
    logic [c_hilo_w-1:0] r_main_mul;
    hilo_we_t            r_main_hilo_we;

    logic                r_skid_valid;
    logic [DATA_W-1:0]   r_skid_result;
    logic [RADDR_W-1:0]  r_skid_rd;
    logic                r_skid_reg_we;
    logic [c_hilo_w-1:0] r_skid_mul;
    hilo_we_t            r_skid_hilo_we;

    logic     w_accept;
    logic     w_retire;
    logic     w_main_free;
    hilo_we_t w_commit_we;

    // A flushed accept is dropped, so it never counts as accepted.
    assign w_accept    = in_valid & ~r_skid_valid & ~flush;
    assign w_retire    = r_main_valid & out_ready;
    assign w_main_free = ~r_main_valid | w_retire;
    assign w_commit_we = {2{w_retire & ~flush}} & r_main_hilo_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            r_main_valid <= r_skid_valid | w_accept;
            r_skid_valid <= 1'b0;
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
        end
    end

    // Main loads from skid when skid holds data; an accept is impossible then.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_result  <= '0;
            r_main_rd      <= '0;
            r_main_reg_we  <= 1'b0;
            r_main_mul     <= '0;
            r_main_hilo_we <= '0;
        end else if (!flush && w_main_free) begin
            if (r_skid_valid) begin
                r_main_result  <= r_skid_result;
                r_main_rd      <= r_skid_rd;
                r_main_reg_we  <= r_skid_reg_we;
                r_main_mul     <= r_skid_mul;
                r_main_hilo_we <= r_skid_hilo_we;
            end else if (w_accept) begin
                r_main_result  <= in_result;
                r_main_rd      <= in_rd;
                r_main_reg_we  <= in_reg_we;
                r_main_mul     <= in_mul;
                r_main_hilo_we <= in_hilo_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_result  <= '0;
            r_skid_rd      <= '0;
            r_skid_reg_we  <= 1'b0;
            r_skid_mul     <= '0;
            r_skid_hilo_we <= '0;
        end else if (w_accept && !w_main_free) begin
            r_skid_result  <= in_result;
            r_skid_rd      <= in_rd;
            r_skid_reg_we  <= in_reg_we;
            r_skid_mul     <= in_mul;
            r_skid_hilo_we <= in_hilo_we;
        end
    end

    hilo_reg #(
        .PAIR_W (c_hilo_w)
    ) u_hilo_reg (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_commit_we),
        .i_hilo (r_main_mul),
        .o_hilo (hilo_arch)
    );

    // Newest writer of one half wins: input, then skid, then main, then arch.
    function automatic logic [DATA_W-1:0] fwd_pick(
        input logic              acc_we,
        input logic [DATA_W-1:0] acc_d,
        input logic              skid_we,
        input logic [DATA_W-1:0] skid_d,
        input logic              main_we,
        input logic [DATA_W-1:0] main_d,
        input logic [DATA_W-1:0] arch_d
    );
        logic [DATA_W-1:0] v;
        v = arch_d;
        if (acc_we)       v = acc_d;
        else if (skid_we) v = skid_d;
        else if (main_we) v = main_d;
        return v;
    endfunction

    assign hilo_fwd = {
        fwd_pick(w_accept & in_hilo_we[HILO_WE_HI], in_mul[c_hilo_w-1 -: DATA_W],
                 r_skid_valid & r_skid_hilo_we[HILO_WE_HI], r_skid_mul[c_hilo_w-1 -: DATA_W],
                 r_main_valid & r_main_hilo_we[HILO_WE_HI], r_main_mul[c_hilo_w-1 -: DATA_W],
                 hilo_arch[c_hilo_w-1 -: DATA_W]),
        fwd_pick(w_accept & in_hilo_we[HILO_WE_LO], in_mul[DATA_W-1:0],
                 r_skid_valid & r_skid_hilo_we[HILO_WE_LO], r_skid_mul[DATA_W-1:0],
                 r_main_valid & r_main_hilo_we[HILO_WE_LO], r_main_mul[DATA_W-1:0],
                 hilo_arch[DATA_W-1:0])
    };

    assign in_ready   = ~r_skid_valid;
    assign out_valid  = r_main_valid;
    assign out_result = r_main_result;
    assign out_rd     = r_main_rd;
    assign out_reg_we = r_main_reg_we;

endmodule : ex_wb_stage
`default_nettype wire

// File: tb/tb_ex_wb_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_ex_wb_stage                                     |
// | Description : Scoreboard bench for ex_wb_stage.                  |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module tb_ex_wb_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [63:0] in_mul;
    logic [4:0]  in_rd;
    logic        in_reg_we;
    logic [1:0]  in_hilo_we;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_we;
    logic [63:0] hilo_fwd;
    logic [63:0] hilo_arch;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;

    ex_wb_stage #(
        .DATA_W  (32),
        .RADDR_W (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_mul     (in_mul),
        .in_rd      (in_rd),
        .in_reg_we  (in_reg_we),
        .in_hilo_we (in_hilo_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_reg_we (out_reg_we),
        .hilo_fwd   (hilo_fwd),
        .hilo_arch  (hilo_arch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] res, input logic [63:0] mul,
                          input logic [4:0] rd, input logic rwe, input logic [1:0] hwe);
        in_valid   = v;
        in_result  = res;
        in_mul     = mul;
        in_rd      = rd;
        in_reg_we  = rwe;
        in_hilo_we = hwe;
    endtask

    task automatic idle();
        set_in(1'b0, 32'h0, 64'h0, 5'd0, 1'b0, 2'b00);
    endtask

    // Mid-cycle: record what the stage accepts this cycle.
    task automatic half();
        exp_t e;
        @(negedge clk);
        if (rst || flush) begin
            q.delete();
        end else if (in_valid && in_ready) begin
            e.res = in_result;
            e.rd  = in_rd;
            e.we  = in_reg_we;
            q.push_back(e);
        end
    endtask

    task automatic rise();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        total = 0;
        bad   = 0;
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        idle();

        fork
            forever begin
                @(negedge clk);
                if (!rst && !flush && out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("sb_unexpected_out", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        check("sb_result", 64'(out_result), 64'(e.res));
                        check("sb_rd",     64'(out_rd),     64'(e.rd));
                        check("sb_reg_we", 64'(out_reg_we), 64'(e.we));
                    end
                end
            end
        join_none

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        half();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_hilo_arch", hilo_arch, 64'd0);
        check("rst_hilo_fwd",  hilo_fwd,  64'd0);
        rise();

        // Streaming 1..4
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) set_in(1'b1, 32'(k), 64'h0, 5'(k), 1'b1, 2'b00);
            else        idle();
            half();
            if (k > 1) begin
                check("stream_valid",  64'(out_valid),  64'd1);
                check("stream_result", 64'(out_result), 64'(k - 1));
            end
            rise();
        end
        idle();
        half(); rise();

        // Backpressure: three pushes, only two fit
        out_ready = 1'b0;
        set_in(1'b1, 32'h10, 64'h0, 5'd10, 1'b1, 2'b00); half(); rise();
        set_in(1'b1, 32'h11, 64'h0, 5'd11, 1'b0, 2'b00); half(); rise();
        set_in(1'b1, 32'h12, 64'h0, 5'd12, 1'b1, 2'b00);
        half();
        check("bp_in_ready", 64'(in_ready),   64'd0);
        check("bp_head",     64'(out_result), 64'h10);
        rise();
        half();
        check("bp_hold_head", 64'(out_result), 64'h10);
        rise();
        out_ready = 1'b1;
        half();
        check("bp_still_full", 64'(in_ready), 64'd0);
        rise();
        half();
        check("bp_ready_rise", 64'(in_ready),   64'd1);
        check("bp_second",     64'(out_result), 64'h11);
        rise();
        idle();
        half();
        check("bp_third", 64'(out_result), 64'h12);
        rise();
        half(); rise();

        // MUL then MADD with HI/LO forwarding
        out_ready = 1'b0;
        set_in(1'b1, 32'h100, 64'h0000_0000_3A98_0000, 5'd0, 1'b0, 2'b11);
        half();
        check("mul_fwd_input", hilo_fwd, 64'h0000_0000_3A98_0000);
        rise();
        idle();
        half();
        check("mul_fwd_main", hilo_fwd, 64'h0000_0000_3A98_0000);
        rise();
        set_in(1'b1, 32'h101, 64'h0000_0000_7530_0000, 5'd0, 1'b0, 2'b11);
        half();
        check("madd_fwd_input", hilo_fwd, 64'h0000_0000_7530_0000);
        rise();
        idle();
        half();
        check("madd_fwd_skid", hilo_fwd, 64'h0000_0000_7530_0000);
        check("madd_arch_pre", hilo_arch, 64'd0);
        rise();
        out_ready = 1'b1;
        half(); rise();
        half();
        check("mul_arch", hilo_arch, 64'h0000_0000_3A98_0000);
        rise();
        half();
        check("madd_arch", hilo_arch, 64'h0000_0000_7530_0000);
        check("madd_fwd_idle", hilo_fwd, 64'h0000_0000_7530_0000);
        rise();

        // Partial writes: MTLO then MTHI
        set_in(1'b1, 32'h200, 64'h0000_0000_0000_0005, 5'd0, 1'b0, 2'b01); half(); rise();
        idle(); half(); rise();
        half();
        check("mtlo_arch", hilo_arch, 64'h0000_0000_0000_0005);
        rise();
        set_in(1'b1, 32'h201, 64'hDEAD_BEEF_FFFF_FFFF, 5'd0, 1'b0, 2'b10);
        half();
        check("mthi_fwd_split", hilo_fwd, 64'hDEAD_BEEF_0000_0005);
        rise();
        idle(); half(); rise();
        half();
        check("mthi_arch", hilo_arch, 64'hDEAD_BEEF_0000_0005);
        rise();

        // Flush with two buffered HI/LO writers and a ready writeback
        out_ready = 1'b0;
        set_in(1'b1, 32'h300, 64'h1111_1111_1111_1111, 5'd3, 1'b1, 2'b11); half(); rise();
        set_in(1'b1, 32'h301, 64'h2222_2222_2222_2222, 5'd4, 1'b1, 2'b11); half(); rise();
        idle();
        out_ready = 1'b1;
        flush = 1'b1;
        half();
        check("flush_pre_fwd", hilo_fwd, 64'h2222_2222_2222_2222);
        rise();
        flush = 1'b0;
        half();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        check("flush_arch",      hilo_arch, 64'hDEAD_BEEF_0000_0005);
        check("flush_fwd",       hilo_fwd,  64'hDEAD_BEEF_0000_0005);
        rise();

        // Flush drops a same-cycle accept
        out_ready = 1'b0;
        set_in(1'b1, 32'h310, 64'h3333_3333_3333_3333, 5'd5, 1'b1, 2'b11); half(); rise();
        set_in(1'b1, 32'h311, 64'h4444_4444_4444_4444, 5'd6, 1'b1, 2'b11);
        flush = 1'b1;
        half(); rise();
        flush = 1'b0;
        idle();
        half();
        check("flush_drop_valid", 64'(out_valid), 64'd0);
        check("flush_drop_arch",  hilo_arch, 64'hDEAD_BEEF_0000_0005);
        rise();

        // Reset while two entries are buffered
        set_in(1'b1, 32'h400, 64'h5555_5555_5555_5555, 5'd7, 1'b1, 2'b11); half(); rise();
        set_in(1'b1, 32'h401, 64'h6666_6666_6666_6666, 5'd8, 1'b1, 2'b11); half(); rise();
        idle();
        out_ready = 1'b1;
        rst = 1'b1;
        half(); rise();
        rst = 1'b0;
        half();
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_in_ready",  64'(in_ready),  64'd1);
        check("rst2_arch",      hilo_arch, 64'd0);
        check("rst2_fwd",       hilo_fwd,  64'd0);
        rise();

        // Control-discarded entry still flows after reset
        set_in(1'b1, 32'h77, 64'h0, 5'd9, 1'b0, 2'b00); half(); rise();
        idle();
        repeat (3) begin
            half(); rise();
        end
        check("sb_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ex_wb_stage
`default_nettype wire
